ber_sweep_ctrl: RTL and testbench
=================================

Name: ber_sweep_ctrl

Overview:
- Synthesizable multi-lane BER evaluation controller for the IB layered LDPC decoder evaluation top.
- Accepts per-frame error-bit counts from LANE_NUM parallel decoder lanes and accumulates frames, error frames and error bits for the current SNR point.
- Closes an SNR point when the error-frame limit or the frame limit is reached, then hands off a report record and steps to the next SNR index. Asserts done after the last SNR point.

Parameters:
- LANE_NUM, 4, number of decoder lanes reporting frames in parallel.
- ERR_BIT_W, 13, width of one lane's per-frame error-bit count; 13 bits covers N=7650.
- ERR_FRAME_HALT, 100, error frames required to close an SNR point.
- MAX_FRAMES, 1000000, frame cap per SNR point; closes the point even when ERR_FRAME_HALT is not reached.
- FRAME_CNT_W, 32, width of the frame and error-frame counters.
- ACC_W, 48, width of the error-bit accumulator.
- SNR_SET_NUM, 8, number of SNR points in one sweep.
- START_SNR, 0, first SNR index.
- SNR_ADDR_W, $clog2(START_SNR+SNR_SET_NUM), width of snr_packet.

Ports:
- read_clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a sweep. Sampled only in IDLE.
- frame_valid, in, LANE_NUM, per-lane strobe: that lane's frame result is present this cycle.
- frame_err_bits, in, LANE_NUM*ERR_BIT_W, per-lane error-bit count. Lane i occupies bits [i*ERR_BIT_W +: ERR_BIT_W].
- frame_ready, out, 1, high when results are accepted.
- snr_packet, out, SNR_ADDR_W, current SNR index fed to the AWGN source.
- snr_update, out, 1, one-cycle pulse when snr_packet changes.
- report_valid, out, 1, report record valid.
- report_ready, in, 1, consumer accepts the report.
- report_snr, out, SNR_ADDR_W, SNR index of the report.
- report_frames, out, FRAME_CNT_W, frames counted at this SNR point.
- report_err_frames, out, FRAME_CNT_W, error frames counted at this SNR point.
- report_err_bits, out, ACC_W, accumulated error bits at this SNR point.
- busy, out, 1, high in every state except IDLE and DONE.
- done, out, 1, high while in DONE.

Behaviour:
- Reset values:
  - State is IDLE.
  - All counters are 0.
  - snr_packet = START_SNR.
  - All outputs are 0 except snr_packet.
- Reset asserted in any state aborts the sweep. No report is emitted.
- FSM states: IDLE, RUN, REPORT, NEXT, DONE.
- IDLE: start=1 moves to RUN on the next cycle. frame_valid is ignored.
- RUN:
  - frame_ready=1.
  - A lane is accepted when its frame_valid bit is set while frame_ready=1.
  - Each cycle, frames increases by popcount(accepted lanes).
  - err_frames increases by the number of accepted lanes whose count is nonzero.
  - err_bits increases by the sum of the accepted lanes' counts.
  - Counts from all lanes in one cycle are added in a single adder tree.
  - All counters saturate at all-ones and never wrap.
  - Halt check runs on the updated values: if err_frames >= ERR_FRAME_HALT or frames >= MAX_FRAMES, go to REPORT on the next cycle.
  - Every lane accepted in the crossing cycle is counted, so err_frames may exceed ERR_FRAME_HALT by up to LANE_NUM-1.
  - Latency is 1 cycle: the counters reflect a result in the cycle after it is accepted.
- REPORT:
  - frame_ready=0. Any frame_valid is dropped and not counted.
  - report_valid=1, with the report fields registered from the counters on entry.
  - report_valid and the fields are held stable until report_ready=1.
  - report_ready may already be high on entry; the handshake then completes in one cycle.
  - On handshake: go to DONE if snr_packet == START_SNR+SNR_SET_NUM-1, otherwise go to NEXT.
- NEXT (one cycle):
  - snr_packet increments.
  - snr_update pulses high.
  - All counters clear.
  - Return to RUN.
  - frame_ready=0 during NEXT.
- DONE:
  - done=1 and busy=0.
  - A start pulse clears the counters, reloads snr_packet=START_SNR, pulses snr_update, and enters RUN.
- start is ignored in RUN, REPORT and NEXT.
- Frame results arriving while frame_ready=0 are lost; the upstream side must stall.

Test Plan:
- SNR_SET_NUM=2, LANE_NUM=1, ERR_FRAME_HALT=3:
  - Stimulus: feed counts 0,5,0,7,2.
  - Required: report 0 gives frames=5, err_frames=3, err_bits=14, report_snr=START_SNR.
  - Required: snr_update pulses once.
  - Required: after the second report, done=1.
- LANE_NUM=4, all lanes valid in one cycle with counts 1,2,0,4, ERR_FRAME_HALT=2:
  - Required: the next cycle shows frames=4, err_frames=3, err_bits=7, followed by REPORT.
- MAX_FRAMES=10, all counts 0:
  - Required: report with frames=10, err_frames=0, err_bits=0.
- Back-pressure, report_ready held low for 20 cycles:
  - Required: report_valid stays high and the fields stay stable.
  - Required: frame_valid pulses during the stall do not change the counts of the next report.
- Reset pulsed during RUN after 3 frames:
  - Required: next cycle shows IDLE, counters 0, snr_packet=START_SNR, report_valid=0.
  - Required: a new start pulse begins a clean sweep.
- Saturation, ACC_W=8, 40 error frames of count 10:
  - Required: report_err_bits=255.

Source files
------------

// File: rtl/ber_sweep_ctrl.sv
// BER sweep controller: accumulates per-lane frame results for one SNR point,
// closes the point on an error-frame or frame limit, reports it and steps the SNR index.
module ber_sweep_ctrl #(
    parameter int LANE_NUM       = 4,
    parameter int ERR_BIT_W      = 13,
    parameter int ERR_FRAME_HALT = 100,
    parameter int MAX_FRAMES     = 1000000,
    parameter int FRAME_CNT_W    = 32,
    parameter int ACC_W          = 48,
    parameter int SNR_SET_NUM    = 8,
    parameter int START_SNR      = 0,
    parameter int SNR_ADDR_W     = $clog2(START_SNR + SNR_SET_NUM)
) (
    input  logic                          read_clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LANE_NUM-1:0]           frame_valid,
    input  logic [LANE_NUM*ERR_BIT_W-1:0] frame_err_bits,
    output logic                          frame_ready,
    output logic [SNR_ADDR_W-1:0]         snr_packet,
    output logic                          snr_update,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [SNR_ADDR_W-1:0]         report_snr,
    output logic [FRAME_CNT_W-1:0]        report_frames,
    output logic [FRAME_CNT_W-1:0]        report_err_frames,
    output logic [ACC_W-1:0]              report_err_bits,
    output logic                          busy,
    output logic                          done
);

    localparam int LCNT_W   = $clog2(LANE_NUM + 1);
    localparam int SUM_W    = ERR_BIT_W + $clog2(LANE_NUM + 1);
    localparam int CNT_EXT  = FRAME_CNT_W + 1;
    localparam int ACC_EXT  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int LAST_SNR = START_SNR + SNR_SET_NUM - 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_REPORT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [FRAME_CNT_W-1:0] frames;
    logic [FRAME_CNT_W-1:0] err_frames;
    logic [ACC_W-1:0]       err_bits;

    logic [LCNT_W-1:0]      lane_frames;
    logic [LCNT_W-1:0]      lane_err_frames;
    logic [SUM_W-1:0]       lane_sum;
    logic [ERR_BIT_W-1:0]   lane_bits;

    logic [CNT_EXT-1:0]     frames_sum;
    logic [CNT_EXT-1:0]     err_frames_sum;
    logic [ACC_EXT-1:0]     acc_sum;
    logic [FRAME_CNT_W-1:0] frames_nxt;
    logic [FRAME_CNT_W-1:0] err_frames_nxt;
    logic [ACC_W-1:0]       err_bits_nxt;

    logic halt;
    logic last_snr;

    // Per-cycle contribution of all accepted lanes, summed in one combinational tree.
    always_comb begin
        lane_frames     = '0;
        lane_err_frames = '0;
        lane_sum        = '0;
        lane_bits       = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            lane_bits = frame_err_bits[i*ERR_BIT_W +: ERR_BIT_W];
            if (frame_valid[i] && frame_ready) begin
                lane_frames = lane_frames + LCNT_W'(1);
                if (lane_bits != '0) begin
                    lane_err_frames = lane_err_frames + LCNT_W'(1);
                end
                lane_sum = lane_sum + SUM_W'(lane_bits);
            end
        end
    end

    // Saturating updates: one extra headroom bit flags overflow.
    always_comb begin
        frames_sum     = CNT_EXT'(frames) + CNT_EXT'(lane_frames);
        err_frames_sum = CNT_EXT'(err_frames) + CNT_EXT'(lane_err_frames);
        acc_sum        = ACC_EXT'(err_bits) + ACC_EXT'(lane_sum);
        frames_nxt     = frames_sum[FRAME_CNT_W] ? '1 : frames_sum[FRAME_CNT_W-1:0];
        err_frames_nxt = err_frames_sum[FRAME_CNT_W] ? '1 : err_frames_sum[FRAME_CNT_W-1:0];
        err_bits_nxt   = (acc_sum > ACC_EXT'(ACC_MAX)) ? '1 : acc_sum[ACC_W-1:0];
        halt           = (err_frames_nxt >= FRAME_CNT_W'(ERR_FRAME_HALT)) ||
                         (frames_nxt >= FRAME_CNT_W'(MAX_FRAMES));
        last_snr       = (snr_packet == SNR_ADDR_W'(LAST_SNR));
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                frame_ready = 1'b1;
                if (halt) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (report_ready) begin
                    state_nxt = last_snr ? S_DONE : S_NEXT;
                end
            end
            S_NEXT: begin
                state_nxt = S_RUN;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Report fields are captured from the updated counters on the edge that closes the point.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            frames            <= '0;
            err_frames        <= '0;
            err_bits          <= '0;
            snr_packet        <= SNR_ADDR_W'(START_SNR);
            snr_update        <= 1'b0;
            report_valid      <= 1'b0;
            report_snr        <= '0;
            report_frames     <= '0;
            report_err_frames <= '0;
            report_err_bits   <= '0;
        end else begin
            snr_update <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frames     <= '0;
                        err_frames <= '0;
                        err_bits   <= '0;
                    end
                end
                S_RUN: begin
                    frames     <= frames_nxt;
                    err_frames <= err_frames_nxt;
                    err_bits   <= err_bits_nxt;
                    if (halt) begin
                        report_valid      <= 1'b1;
                        report_snr        <= snr_packet;
                        report_frames     <= frames_nxt;
                        report_err_frames <= err_frames_nxt;
                        report_err_bits   <= err_bits_nxt;
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        if (!last_snr) begin
                            snr_packet <= snr_packet + SNR_ADDR_W'(1);
                            snr_update <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    frames     <= '0;
                    err_frames <= '0;
                    err_bits   <= '0;
                end
                S_DONE: begin
                    if (start) begin
                        frames     <= '0;
                        err_frames <= '0;
                        err_bits   <= '0;
                        snr_packet <= SNR_ADDR_W'(START_SNR);
                        snr_update <= 1'b1;
                    end
                end
                default: begin
                    report_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Randomized bench for ber_sweep_ctrl: a count-level model of each SNR point predicts
// every report; directed scenarios cover the limits, back-pressure, saturation and reset.
`timescale 1ns/1ps
module tb_ber_sweep_ctrl;

    localparam int LANES = 4;
    localparam int EBW   = 13;
    localparam int HALT  = 3;
    localparam int MAXF  = 10;
    localparam int CW    = 16;
    localparam int AW    = 8;
    localparam int SETN  = 3;
    localparam int START = 2;
    localparam int SAW   = 3;
    localparam int LAST  = START + SETN - 1;
    localparam int RW    = SAW + CW + CW + AW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [LANES-1:0]       frame_valid = '0;
    logic [LANES*EBW-1:0]   frame_err_bits = '0;
    logic                   report_ready = 1'b0;
    logic                   frame_ready;
    logic [SAW-1:0]         snr_packet;
    logic                   snr_update;
    logic                   report_valid;
    logic [SAW-1:0]         report_snr;
    logic [CW-1:0]          report_frames;
    logic [CW-1:0]          report_err_frames;
    logic [AW-1:0]          report_err_bits;
    logic                   busy;
    logic                   done;

    ber_sweep_ctrl #(
        .LANE_NUM(LANES), .ERR_BIT_W(EBW), .ERR_FRAME_HALT(HALT), .MAX_FRAMES(MAXF),
        .FRAME_CNT_W(CW), .ACC_W(AW), .SNR_SET_NUM(SETN), .START_SNR(START), .SNR_ADDR_W(SAW)
    ) dut (
        .read_clk(clk), .rst(rst), .start(start),
        .frame_valid(frame_valid), .frame_err_bits(frame_err_bits),
        .frame_ready(frame_ready), .snr_packet(snr_packet), .snr_update(snr_update),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_snr(report_snr), .report_frames(report_frames),
        .report_err_frames(report_err_frames), .report_err_bits(report_err_bits),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [RW-1:0] exp_q[$];

    // Reference model of the current SNR point.
    bit     m_running = 1'b0;
    int     m_snr = START;
    longint m_frames, m_errf, m_bits;
    bit     early_ready = 1'b0;

    logic [SAW-1:0] r_snr;
    logic [CW-1:0]  r_frames;
    logic [CW-1:0]  r_errf;
    logic [AW-1:0]  r_bits;

    always @(negedge clk) begin
        if (!rst && snr_update === 1'b1) upd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog timeout");
    end

    task automatic model_accept(input logic [LANES-1:0] v, input logic [LANES*EBW-1:0] b);
        logic [EBW-1:0] c;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                c = b[i*EBW +: EBW];
                m_frames++;
                if (c != 0) m_errf++;
                m_bits += c;
            end
        end
        if (m_frames > (1 << CW) - 1) m_frames = (1 << CW) - 1;
        if (m_errf > (1 << CW) - 1) m_errf = (1 << CW) - 1;
        if (m_bits > (1 << AW) - 1) m_bits = (1 << AW) - 1;
        if (m_errf >= HALT || m_frames >= MAXF) begin
            exp_q.push_back({SAW'(m_snr), CW'(m_frames), CW'(m_errf), AW'(m_bits)});
            m_running = 1'b0;
        end
    endtask

    task automatic model_open_point(input int snr);
        m_snr = snr;
        m_frames = 0;
        m_errf = 0;
        m_bits = 0;
        m_running = 1'b1;
    endtask

    task automatic feed(input logic [LANES-1:0] v, input logic [LANES*EBW-1:0] b);
        @(negedge clk);
        frame_valid = v;
        frame_err_bits = b;
        report_ready = early_ready;
        start = ($urandom_range(0, 7) == 0);
        checks++;
        if (frame_ready !== m_running) begin
            errors++;
            $display("FAIL frame_ready_run: got %b want %b", frame_ready, m_running);
        end
        if (m_running) model_accept(v, b);
    endtask

    task automatic drive_noise();
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        frame_valid = LANES'($urandom());
        frame_err_bits = rnd[LANES*EBW-1:0];
    endtask

    task automatic start_sweep(input bit from_done);
        @(negedge clk);
        frame_valid = '0;
        report_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            snr_packet !== SAW'(START) || snr_update !== from_done) begin
            errors++;
            $display("FAIL start_sweep: ready=%b busy=%b done=%b snr=%0d upd=%b want 1 1 0 %0d %b",
                     frame_ready, busy, done, snr_packet, snr_update, START, from_done);
        end
        model_open_point(START);
    endtask

    task automatic take_report(input int stall);
        logic [RW-1:0] exp;
        logic [RW-1:0] held;
        int eff_stall;
        eff_stall = early_ready ? 0 : stall;
        @(negedge clk);
        frame_valid = '0;
        start = 1'b0;
        report_ready = early_ready;
        checks++;
        if (report_valid !== 1'b1) begin
            errors++;
            $display("FAIL report_latency: report_valid=%b one cycle after close, want 1", report_valid);
            for (int i = 0; i < 10 && report_valid !== 1'b1; i++) @(negedge clk);
            if (report_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL report_timeout: report_valid=%b after 10 cycles, want 1", report_valid);
                return;
            end
        end
        held = {report_snr, report_frames, report_err_frames, report_err_bits};
        {r_snr, r_frames, r_errf, r_bits} = held;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL report_unexpected: got snr=%0d frames=%0d errf=%0d bits=%0d, want none",
                     r_snr, r_frames, r_errf, r_bits);
        end else begin
            exp = exp_q.pop_front();
            if (held !== exp) begin
                errors++;
                $display("FAIL report_fields: got snr=%0d frames=%0d errf=%0d bits=%0d want snr=%0d frames=%0d errf=%0d bits=%0d",
                         r_snr, r_frames, r_errf, r_bits,
                         exp[RW-1 -: SAW], exp[CW+CW+AW-1 -: CW], exp[CW+AW-1 -: CW], exp[AW-1:0]);
            end
        end
        for (int i = 0; i < eff_stall; i++) begin
            report_ready = 1'b0;
            drive_noise();
            @(negedge clk);
            checks++;
            if (report_valid !== 1'b1 || frame_ready !== 1'b0 ||
                {report_snr, report_frames, report_err_frames, report_err_bits} !== held) begin
                errors++;
                $display("FAIL report_stall: cycle %0d valid=%b ready=%b frames=%0d errf=%0d bits=%0d, want held values",
                         i, report_valid, frame_ready, report_frames, report_err_frames, report_err_bits);
            end
        end
        report_ready = 1'b1;
        drive_noise();
        @(negedge clk);
        report_ready = 1'b0;
        drive_noise();
        checks++;
        if (m_snr == LAST) begin
            if (done !== 1'b1 || busy !== 1'b0 || report_valid !== 1'b0 || frame_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep_done: done=%b busy=%b valid=%b ready=%b want 1 0 0 0",
                         done, busy, report_valid, frame_ready);
            end
            @(negedge clk);
            frame_valid = '0;
        end else begin
            if (snr_update !== 1'b1 || snr_packet !== SAW'(m_snr + 1) || frame_ready !== 1'b0 ||
                report_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL snr_step: upd=%b snr=%0d ready=%b valid=%b busy=%b want 1 %0d 0 0 1",
                         snr_update, snr_packet, frame_ready, report_valid, busy, m_snr + 1);
            end
            @(negedge clk);
            frame_valid = '0;
            checks++;
            if (frame_ready !== 1'b1 || snr_update !== 1'b0) begin
                errors++;
                $display("FAIL run_resume: ready=%b upd=%b want 1 0", frame_ready, snr_update);
            end
            model_open_point(m_snr + 1);
        end
    endtask

    task automatic run_point(input int stall);
        logic [LANES-1:0]     v;
        logic [LANES*EBW-1:0] b;
        for (int n = 0; n < 100 && m_running; n++) begin
            v = LANES'($urandom());
            b = '0;
            for (int i = 0; i < LANES; i++) begin
                b[i*EBW +: EBW] = ($urandom_range(0, 1) == 0) ? '0 : EBW'($urandom_range(1, 40));
            end
            feed(v, b);
        end
        take_report(stall);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        frame_valid = '0;
        report_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_ready !== 1'b0 || report_valid !== 1'b0 ||
            snr_update !== 1'b0 || snr_packet !== SAW'(START)) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ready=%b valid=%b upd=%b snr=%0d want 0 0 0 0 0 %0d",
                     busy, done, frame_ready, report_valid, snr_update, snr_packet, START);
        end
        m_running = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_ready !== 1'b0 || report_valid !== 1'b0 ||
            snr_update !== 1'b0 || snr_packet !== SAW'(START) || report_snr !== '0 ||
            report_frames !== '0 || report_err_frames !== '0 || report_err_bits !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b ready=%b valid=%b upd=%b snr=%0d fields=%0d/%0d/%0d/%0d",
                     busy, done, frame_ready, report_valid, snr_update, snr_packet,
                     report_snr, report_frames, report_err_frames, report_err_bits);
        end
        drive_noise();
        @(negedge clk);
        frame_valid = '0;
        checks++;
        if (busy !== 1'b0 || frame_ready !== 1'b0 || report_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_frames: busy=%b ready=%b valid=%b want 0 0 0",
                     busy, frame_ready, report_valid);
        end
    endtask

    task automatic test_serial_counts();
        int cnts[5] = '{0, 5, 0, 7, 2};
        logic [LANES*EBW-1:0] b;
        int base;
        base = upd_cnt;
        start_sweep(1'b0);
        foreach (cnts[i]) begin
            b = '0;
            b[EBW-1:0] = EBW'(cnts[i]);
            feed(4'b0001, b);
        end
        take_report(0);
        checks++;
        if (r_snr !== SAW'(START) || r_frames !== 16'd5 || r_errf !== 16'd3 || r_bits !== 8'd14) begin
            errors++;
            $display("FAIL serial_report: got snr=%0d frames=%0d errf=%0d bits=%0d want %0d 5 3 14",
                     r_snr, r_frames, r_errf, r_bits, START);
        end
        checks++;
        if (upd_cnt - base !== 1) begin
            errors++;
            $display("FAIL snr_update_count: got %0d pulses want 1", upd_cnt - base);
        end
    endtask

    task automatic test_parallel_lanes();
        feed(4'b1111, {13'd4, 13'd0, 13'd2, 13'd1});
        take_report(0);
        checks++;
        if (r_snr !== SAW'(START + 1) || r_frames !== 16'd4 || r_errf !== 16'd3 || r_bits !== 8'd7) begin
            errors++;
            $display("FAIL parallel_report: got snr=%0d frames=%0d errf=%0d bits=%0d want %0d 4 3 7",
                     r_snr, r_frames, r_errf, r_bits, START + 1);
        end
    endtask

    task automatic test_frame_cap();
        early_ready = 1'b1;
        feed(4'b1111, '0);
        feed(4'b1111, '0);
        feed(4'b0011, '0);
        take_report(0);
        early_ready = 1'b0;
        checks++;
        if (r_snr !== SAW'(LAST) || r_frames !== 16'd10 || r_errf !== 16'd0 || r_bits !== 8'd0) begin
            errors++;
            $display("FAIL frame_cap_report: got snr=%0d frames=%0d errf=%0d bits=%0d want %0d 10 0 0",
                     r_snr, r_frames, r_errf, r_bits, LAST);
        end
    endtask

    task automatic test_back_pressure();
        start_sweep(1'b1);
        run_point(20);
        for (int p = 1; p < SETN; p++) begin
            early_ready = ($urandom_range(0, 1) == 1);
            run_point($urandom_range(0, 3));
        end
        early_ready = 1'b0;
    endtask

    task automatic test_saturation();
        start_sweep(1'b1);
        feed(4'b0010, {13'd0, 13'd0, 13'd100, 13'd0});
        feed(4'b0100, {13'd0, 13'd100, 13'd0, 13'd0});
        feed(4'b1000, {13'd100, 13'd0, 13'd0, 13'd0});
        take_report(0);
        checks++;
        if (r_bits !== 8'd255 || r_errf !== 16'd3 || r_frames !== 16'd3) begin
            errors++;
            $display("FAIL saturation: got bits=%0d errf=%0d frames=%0d want 255 3 3",
                     r_bits, r_errf, r_frames);
        end
    endtask

    task automatic test_reset_mid_run();
        feed(4'b0001, '0);
        feed(4'b0001, '0);
        feed(4'b0001, '0);
        reset_dut();
        start_sweep(1'b0);
        for (int p = 0; p < SETN; p++) begin
            early_ready = ($urandom_range(0, 1) == 1);
            run_point($urandom_range(0, 2));
        end
        early_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_reports: %0d expected reports never seen", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_serial_counts();
        test_parallel_lanes();
        test_frame_cap();
        test_back_pressure();
        test_saturation();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
